// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: frame controller for a SIPO shift-register datapath.
// Finds start/data/stop framing on sIn, strobes shift once per data
// bit, checks the stop bit and latches the datapath word.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   en       enable; low aborts a frame and holds IDLE
//   sIn      serial line (idle high), also the datapath serial input
//   pIn      datapath parallel output
//   shift    datapath mux select, 1 = shift sIn in
//   dataOut  last correctly framed word
//   valid    one-cycle pulse, dataOut updated
//   frameErr one-cycle pulse, stop bit sampled low
//   busy     high whenever not IDLE
module sipo_rx_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sIn,
    input  logic [WIDTH-1:0] pIn,
    output logic             shift,
    output logic [WIDTH-1:0] dataOut,
    output logic             valid,
    output logic             frameErr,
    output logic             busy
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] B_PRE  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    r_bitCnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             w_last;

    assign w_last   = (r_cnt == C_LAST);
    // Decoded from registered state so the datapath sees a clean select.
    assign shift    = (r_state == DATA) && w_last;
    assign busy     = (r_state != IDLE);
    assign dataOut  = r_data;
    assign valid    = r_valid;
    assign frameErr = r_ferr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bitCnt <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if (!en) begin
                r_state  <= IDLE;
                r_cnt    <= '0;
                r_bitCnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!sIn) begin
                            r_state <= START;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    START: begin
                        // Any high sample during the start bit is a glitch.
                        if (sIn) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == C_HALF) begin
                            r_state  <= DATA;
                            r_cnt    <= '0;
                            r_bitCnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (w_last) begin
                            r_cnt    <= '0;
                            r_bitCnt <= r_bitCnt + 1'b1;
                            if (r_bitCnt == B_PRE) begin
                                r_state <= STOP;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (w_last) begin
                            r_cnt <= '0;
                            if (sIn) begin
                                r_state <= IDLE;
                                r_data  <= pIn;
                                r_valid <= 1'b1;
                            end else begin
                                r_state <= BREAK;
                                r_ferr  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    BREAK: begin
                        // Wait for the line to return high before rearming.
                        if (sIn) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// tb_sipo_rx_ctrl: scoreboard bench for sipo_rx_ctrl.
// Includes a behavioural model of the shift-register datapath.
module tb_sipo_rx_ctrl;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b1;
    logic         sIn = 1'b1;
    logic [W-1:0] pIn;
    logic         shift;
    logic [W-1:0] dataOut;
    logic         valid;
    logic         frameErr;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit           err;
        logic [W-1:0] data;
        int           t;
    } ev_t;

    ev_t          expq[$];
    int           shq[$];
    logic [W-1:0] last_good = '0;
    logic [W-1:0] q = '0;

    sipo_rx_ctrl #(.WIDTH(W), .DIV(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sIn      (sIn),
        .pIn      (pIn),
        .shift    (shift),
        .dataOut  (dataOut),
        .valid    (valid),
        .frameErr (frameErr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath: sIn enters the MSB and the word moves toward bit 0.
    always @(posedge clk) if (shift) q <= {sIn, q[W-1:1]};
    assign pIn = q;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        ev_t ev;
        int  ts;
        if (shift) begin
            if (shq.size() == 0) begin
                chk("unexpected_shift", 1, 0);
            end else begin
                ts = shq.pop_front();
                chk("shift_edge", cyc + 1, ts);
            end
        end
        if (valid && frameErr) chk("both_pulses", 1, 0);
        if (valid || frameErr) begin
            if (expq.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                ev = expq.pop_front();
                chk("pulse_kind", int'(frameErr), int'(ev.err));
                chk("pulse_data", int'(dataOut), int'(ev.data));
                chk("pulse_time", cyc, ev.t);
            end
        end
    end

    // Called at a negedge; the next rising edge is E0.
    task automatic send_frame(input logic [W-1:0] d,
                              input bit stop, input int tail);
        int  e0;
        ev_t ev;
        e0 = cyc + 1;
        for (int k = 0; k < W; k++)
            shq.push_back(e0 + D / 2 + D * (k + 1));
        ev.err  = !stop;
        ev.data = stop ? d : last_good;
        ev.t    = e0 + D / 2 + (W + 1) * D;
        expq.push_back(ev);
        if (stop) last_good = d;
        sIn = 1'b0;
        repeat (D) @(negedge clk);
        for (int k = 0; k < W; k++) begin
            sIn = d[k];
            repeat (D) @(negedge clk);
        end
        sIn = stop;
        repeat (D) @(negedge clk);
        if (!stop) begin
            for (int i = 0; i < tail; i++) begin
                chk("break_busy", int'(busy), 1);
                @(negedge clk);
            end
            sIn = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        sIn = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset held with a toggling line.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sIn = i[0];
            #1;
            chk("reset_outs",
                int'({valid, frameErr, busy, shift, dataOut}), 0);
        end
        @(negedge clk);
        sIn = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_reset_idle", int'({busy, shift}), 0);
        end

        // Directed good frame: bits 1,0,1,1 -> 4'b1101.
        send_frame(4'b1101, 1'b1, 0);
        chk("good_dataout", int'(dataOut), 4'b1101);
        idle(3);

        // Start glitch: one low cycle.
        sIn = 1'b0;
        @(negedge clk);
        sIn = 1'b1;
        chk("glitch_busy_hi", int'(busy), 1);
        @(negedge clk);
        chk("glitch_busy_lo", int'(busy), 0);
        idle(4);

        // Framing error with the line held low.
        send_frame(4'b0110, 1'b0, 6);
        chk("ferr_keep_data", int'(dataOut), 4'b1101);
        idle(2);
        chk("ferr_idle", int'(busy), 0);

        // Abort after the second shift.
        shq.push_back(cyc + 1 + D / 2 + D);
        shq.push_back(cyc + 1 + D / 2 + 2 * D);
        sIn = 1'b0;
        repeat (D) @(negedge clk);
        sIn = 1'b1;
        repeat (D) @(negedge clk);
        sIn = 1'b0;
        repeat (D) @(negedge clk);
        en = 1'b0;
        sIn = 1'b1;
        @(negedge clk);
        chk("abort_idle", int'(busy), 0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        send_frame(4'b0011, 1'b1, 0);
        chk("abort_recover", int'(dataOut), 4'b0011);
        idle(2);

        // Back-to-back frames.
        send_frame(4'hA, 1'b1, 0);
        chk("b2b_first", int'(dataOut), 4'hA);
        send_frame(4'h5, 1'b1, 0);
        chk("b2b_second", int'(dataOut), 4'h5);
        idle(2);

        // Reset mid-frame, then a fresh frame.
        sIn = 1'b0;
        repeat (D + 1) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_outs",
            int'({valid, frameErr, busy, shift, dataOut}), 0);
        last_good = '0;
        @(negedge clk);
        sIn = 1'b1;
        rst = 1'b1;
        idle(3);
        send_frame(4'h9, 1'b1, 0);
        idle(1);

        // Randomized frames with occasional bad stop bits.
        for (int n = 0; n < 20; n++) begin
            logic [W-1:0] d;
            bit           st;
            d  = W'($urandom);
            st = ($urandom_range(0, 4) != 0);
            send_frame(d, st, $urandom_range(0, 6));
            idle($urandom_range(0, 3));
        end

        // Bounded drain of outstanding expectations.
        for (int i = 0; i < 8 * D; i++) begin
            if (expq.size() == 0 && shq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_events", expq.size(), 0);
        chk("drain_shifts", shq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
